// File: rtl/sevenseg_scan_driver_if.sv
// Bus between design logic and the seven-segment scan driver.
//   value       : hex digits, digit i = value[4i+3:4i], digit 0 rightmost
//   dp          : decimal point request per digit, 1 = lit
//   load        : 1-cycle strobe, capture value/dp into the pending buffer
//   blank_lz    : 1 = blank leading zero digits
//   brightness  : duty, 0 = dark, 1..14 = n/16, 15 = always on
//   display_sel : digit enables, active-low, one-cold or all-1
//   display     : segments {dp,g,f,e,d,c,b,a}, active-low
//   frame_tick  : 1-cycle pulse in the cycle the scan wraps to digit 0
// master = design logic side, slave = driver side.
interface sevenseg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    load;
    logic                    blank_lz;
    logic [3:0]              brightness;
    logic [NUM_DIGITS-1:0]   display_sel;
    logic [7:0]              display;
    logic                    frame_tick;

    modport master (
        output value, dp, load, blank_lz, brightness,
        input  display_sel, display, frame_tick
    );
    modport slave (
        input  value, dp, load, blank_lz, brightness,
        output display_sel, display, frame_tick
    );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed driver for an N-digit common-anode seven-segment display.
// Scans the digits over a shared segment bus with double-buffered data
// (no mixed frames), PWM brightness and optional leading-zero blanking.
//   clk100  : 100 MHz clock, sole clock
//   reset_n : asynchronous active-low reset
//   bus     : sevenseg_scan_driver_if slave (data in, display pins out)
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS  = 4,    // 2..8
    parameter int REFRESH_DIV = 1024  // cycles per digit slot, multiple of 16
) (
    input  logic                   clk100,
    input  logic                   reset_n,
    sevenseg_scan_driver_if.slave  bus
);
    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int PH_DIV = REFRESH_DIV / 16;

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] pending_val, shadow_val;
    logic [NUM_DIGITS-1:0]   pending_dp, shadow_dp;
    logic                    pending_valid;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic [7:0]              disp_q;
    logic                    tick_q;

    logic cnt_tc, last_idx, wrap, tick_d;
    assign cnt_tc   = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign last_idx = (idx == IDX_W'(NUM_DIGITS - 1));
    assign wrap     = cnt_tc && last_idx;
    // Registered pulse that lands on the wrap cycle itself, so a load seen
    // together with frame_tick is a load coinciding with the wrap.
    assign tick_d   = last_idx && (cnt == CNT_W'(REFRESH_DIV - 2));

    function automatic logic [6:0] hex7seg(input logic [3:0] h);
        case (h)
            4'h0: hex7seg = 7'h40;  4'h1: hex7seg = 7'h79;
            4'h2: hex7seg = 7'h24;  4'h3: hex7seg = 7'h30;
            4'h4: hex7seg = 7'h19;  4'h5: hex7seg = 7'h12;
            4'h6: hex7seg = 7'h02;  4'h7: hex7seg = 7'h78;
            4'h8: hex7seg = 7'h00;  4'h9: hex7seg = 7'h10;
            4'hA: hex7seg = 7'h08;  4'hB: hex7seg = 7'h03;
            4'hC: hex7seg = 7'h46;  4'hD: hex7seg = 7'h21;
            4'hE: hex7seg = 7'h06;  default: hex7seg = 7'h0E;
        endcase
    endfunction

    // Next output word, derived from current (cnt, idx, shadow)
    logic [3:0]            digit;
    logic                  dp_bit;
    logic [NUM_DIGITS-1:0] hi_zero;   // digit i and every digit above it are 0
    logic [CNT_W-1:0]      phase;
    logic                  duty_on, blanked;
    logic [NUM_DIGITS-1:0] sel_d;
    logic [7:0]            disp_d;

    always_comb begin
        hi_zero[NUM_DIGITS-1] = (shadow_val[4*(NUM_DIGITS-1) +: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            hi_zero[i] = hi_zero[i+1] && (shadow_val[4*i +: 4] == 4'h0);
    end

    always_comb begin
        digit   = shadow_val[4*idx +: 4];
        dp_bit  = shadow_dp[idx];
        phase   = cnt / CNT_W'(PH_DIV);
        // cnt == 0 is a dark guard cycle between digits against ghosting
        duty_on = ((bus.brightness == 4'hF) || (phase < CNT_W'(bus.brightness)))
                  && (cnt != '0);
        blanked = bus.blank_lz && (idx != '0) && hi_zero[idx];
        sel_d   = '1;
        disp_d  = 8'hFF;
        if (duty_on) begin
            if (!blanked) begin
                sel_d  = ~(NUM_DIGITS'(1) << idx);
                disp_d = {~dp_bit, hex7seg(digit)};
            end else if (dp_bit) begin
                // blanked digit keeps its decimal point
                sel_d  = ~(NUM_DIGITS'(1) << idx);
                disp_d = 8'h7F;
            end
        end
    end

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            cnt           <= '0;
            idx           <= '0;
            pending_val   <= '0;
            pending_dp    <= '0;
            pending_valid <= 1'b0;
            shadow_val    <= '0;
            shadow_dp     <= '0;
            sel_q         <= '1;
            disp_q        <= 8'hFF;
            tick_q        <= 1'b0;
        end else begin
            cnt <= cnt_tc ? '0 : cnt + 1'b1;
            if (cnt_tc)
                idx <= last_idx ? '0 : idx + 1'b1;

            // On a load/wrap collision the old pending goes to shadow and
            // the new data waits in pending for the following frame.
            if (wrap && pending_valid) begin
                shadow_val    <= pending_val;
                shadow_dp     <= pending_dp;
                pending_valid <= 1'b0;
            end
            if (bus.load) begin
                pending_val   <= bus.value;
                pending_dp    <= bus.dp;
                pending_valid <= 1'b1;
            end

            sel_q  <= sel_d;
            disp_q <= disp_d;
            tick_q <= tick_d;
        end
    end

    assign bus.display_sel = sel_q;
    assign bus.display     = disp_q;
    assign bus.frame_tick  = tick_q;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver: a fast instance (REFRESH_DIV=16)
// for data/blanking/buffering checks and a REFRESH_DIV=1024 instance for
// the duty-cycle count. Outputs are sampled 1 time unit after the clock edge.
// Timing model used below: frame_tick is high in the wrap cycle (ofs 0);
// the output seen at offset k shows scan position k-2 of the new frame,
// so slot j at cnt 8 is observed at k = 16*j + 10.
module tb_sevenseg_scan_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sevenseg_scan_driver_if #(.NUM_DIGITS(4)) b16 ();
    sevenseg_scan_driver_if #(.NUM_DIGITS(4)) b1k ();

    sevenseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(16)) u_dut16 (
        .clk100(clk), .reset_n(rst_n), .bus(b16));
    sevenseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(1024)) u_dut1k (
        .clk100(clk), .reset_n(rst_n), .bus(b1k));

    int n_chk  = 0;
    int n_pass = 0;
    int ofs    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
        ofs++;
    endtask

    task automatic goto(input int t);
        while (ofs < t) tick();
    endtask

    task automatic wait_ft();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!b16.frame_tick && n < 200);
        if (!b16.frame_tick) chk("frame_tick_timeout", 32'd0, 32'd1);
        ofs = 0;
    endtask

    task automatic load16(input logic [15:0] v, input logic [3:0] d);
        b16.value = v;
        b16.dp    = d;
        b16.load  = 1'b1;
        tick();
        b16.load  = 1'b0;
    endtask

    task automatic check_slot(input string tag, input int j,
                              input logic [3:0] es, input logic [7:0] ed);
        goto(16*j + 10);
        chk({tag, "_sel"}, 32'(b16.display_sel), 32'(es));
        chk({tag, "_seg"}, 32'(b16.display), 32'(ed));
    endtask

    // d holds the expected segment byte of slot j in d[8j+7:8j]
    task automatic check_frame(input string tag, input logic [31:0] d);
        logic [3:0] one = 4'b0001;
        for (int j = 0; j < 4; j++)
            check_slot($sformatf("%s_d%0d", tag, j), j, ~(one << j), d[8*j +: 8]);
    endtask

    task automatic count16(output int c);
        c = 0;
        wait_ft();
        for (int k = 1; k <= 65; k++) begin
            tick();
            if (k >= 2 && b16.display_sel != 4'hF) c++;
        end
    endtask

    initial begin
        int c;
        int n;
        b16.value = '0; b16.dp = '0; b16.load = 1'b0; b16.blank_lz = 1'b0; b16.brightness = 4'hF;
        b1k.value = '0; b1k.dp = '0; b1k.load = 1'b0; b1k.blank_lz = 1'b0; b1k.brightness = 4'd4;

        // reset state
        #23;
        chk("rst_sel", 32'(b16.display_sel), 32'hF);
        chk("rst_seg", 32'(b16.display), 32'hFF);
        chk("rst_tick", 32'(b16.frame_tick), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // basic display of 1234
        load16(16'h1234, 4'b0000);
        wait_ft();
        check_frame("v1234", {8'hF9, 8'hA4, 8'hB0, 8'h99});

        // tear-free: load during slot 2, old glyphs stay until the wrap
        wait_ft();
        goto(36);
        load16(16'hAAAA, 4'b0000);
        check_slot("tear_d2", 2, 4'b1011, 8'hA4);
        check_slot("tear_d3", 3, 4'b0111, 8'hF9);
        wait_ft();
        check_frame("vAAAA", {4{8'h88}});

        // load in the frame_tick cycle: old pending shows first
        load16(16'hCCCC, 4'b0000);
        wait_ft();
        load16(16'hBBBB, 4'b0000);
        check_frame("coll_old", {4{8'hC6}});
        wait_ft();
        check_frame("coll_new", {4{8'h83}});

        // leading-zero blanking
        b16.blank_lz = 1'b1;
        load16(16'h0050, 4'b1000);
        wait_ft();
        check_slot("lz_d0", 0, 4'b1110, 8'hC0);
        check_slot("lz_d1", 1, 4'b1101, 8'h92);
        check_slot("lz_d2", 2, 4'b1111, 8'hFF);
        check_slot("lz_d3", 3, 4'b0111, 8'h7F);
        b16.blank_lz = 1'b0;
        wait_ft();
        check_slot("nolz_d2", 2, 4'b1011, 8'hC0);
        check_slot("nolz_d3", 3, 4'b0111, 8'h40);

        // brightness duty, REFRESH_DIV=16: on for cnt 1..b-1 per slot
        b16.brightness = 4'd0;  count16(c); chk("duty16_b0", 32'(c), 32'd0);
        b16.brightness = 4'd4;  count16(c); chk("duty16_b4", 32'(c), 32'd12);
        b16.brightness = 4'd14; count16(c); chk("duty16_b14", 32'(c), 32'd52);
        b16.brightness = 4'd15; count16(c); chk("duty16_b15", 32'(c), 32'd60);

        // brightness 4 at REFRESH_DIV=1024: 255 on-cycles per slot
        n = 0;
        do begin
            tick();
            n++;
        end while (!b1k.frame_tick && n < 5000);
        chk("duty1k_tick_seen", 32'(b1k.frame_tick), 32'd1);
        c = 0;
        for (int k = 1; k <= 4097; k++) begin
            tick();
            if (k >= 2 && b1k.display_sel != 4'hF) c++;
        end
        chk("duty1k_b4", 32'(c), 32'd1020);

        // reset mid-scan: dark at once, restart at idx 0 with shadow = 0
        wait_ft();
        goto(20);
        chk("pre_rst_sel", 32'(b16.display_sel), 32'hD);
        rst_n = 1'b0;
        #1;
        chk("midrst_sel", 32'(b16.display_sel), 32'hF);
        chk("midrst_seg", 32'(b16.display), 32'hFF);
        chk("midrst_tick", 32'(b16.frame_tick), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (b16.display_sel == 4'hF && n < 100);
        chk("post_rst_lat", 32'(n), 32'd2);
        chk("post_rst_sel", 32'(b16.display_sel), 32'hE);
        chk("post_rst_seg", 32'(b16.display), 32'hC0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
